// File: rtl/cpu_addr_pkg.sv
// Shared constants for the CPU address path: state encoding and burst direction.
package cpu_addr_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BURST = 1'b1;

    localparam logic DIR_INC = 1'b0;
    localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/addr_burst_reg_beat_counter.sv
// Loadable down-counter tracking remaining burst beats.
// Flags the final beat so the parent can finish the burst.
module beat_counter #(
    parameter int LW = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    input  logic          dec,
    output logic          last
);

    logic [LW-1:0] count;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == LW'(1));

endmodule

// File: rtl/addr_burst_reg.sv
// Address register with valid/ready burst sequencing toward ABUSD.
// Define ADDR_BOUND_EN to stop bursts that would wrap past the address space.
module addr_burst_reg
    import cpu_addr_pkg::*;
#(
    parameter int AW   = 8,
    parameter int LW   = 4,
    parameter int STEP = 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [AW-1:0] load_addr,
    input  logic          LDAR,
    input  logic          burst_start,
    input  logic [LW-1:0] burst_len,
    input  logic          dir,
    input  logic          burst_abort,
    input  logic          addr_ready,
    output logic [AW-1:0] ABUSD,
    output logic          addr_valid,
    output logic          ar_busy,
    output logic          burst_done,
    output logic          addr_err
);

    logic          state;
    logic          dir_q;
    logic          start_ok;
    logic          accept;
    logic          last_beat;
    logic          bound_hit;
    logic [AW-1:0] next_addr;

    assign start_ok = (state == ST_IDLE) && burst_start && (burst_len != '0);
    assign accept   = (state == ST_BURST) && addr_valid && addr_ready;

`ifdef ADDR_BOUND_EN
    localparam logic [AW:0] STEP_X = (AW+1)'(STEP);
    logic [AW:0] sum_ext;

    // Extra top bit captures carry out (inc) or borrow (dec).
    assign sum_ext   = (dir_q == DIR_DEC) ? {1'b0, ABUSD} - STEP_X
                                          : {1'b0, ABUSD} + STEP_X;
    assign next_addr = sum_ext[AW-1:0];
    assign bound_hit = sum_ext[AW] && !last_beat;
`else
    localparam logic [AW-1:0] STEP_A = AW'(STEP);

    assign next_addr = (dir_q == DIR_DEC) ? ABUSD - STEP_A
                                          : ABUSD + STEP_A;
    assign bound_hit = 1'b0;
`endif

    beat_counter #(
        .LW (LW)
    ) u_beat_counter (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .load     (start_ok),
        .load_val (burst_len),
        .dec      (accept),
        .last     (last_beat)
    );

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state      <= ST_IDLE;
            dir_q      <= DIR_INC;
            ABUSD      <= '0;
            addr_valid <= 1'b0;
            ar_busy    <= 1'b0;
            burst_done <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            addr_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (LDAR) begin
                        ABUSD <= load_addr;
                    end
                    if (start_ok) begin
                        state      <= ST_BURST;
                        addr_valid <= 1'b1;
                        ar_busy    <= 1'b1;
                        dir_q      <= dir;
                    end
                end
                ST_BURST: begin
                    if (accept && bound_hit) begin
                        // Boundary beat stays on the bus; burst ends with an error.
                        state      <= ST_IDLE;
                        addr_valid <= 1'b0;
                        ar_busy    <= 1'b0;
                        addr_err   <= 1'b1;
                    end else begin
                        if (accept) begin
                            ABUSD <= next_addr;
                        end
                        if (burst_abort || (accept && last_beat)) begin
                            state      <= ST_IDLE;
                            addr_valid <= 1'b0;
                            ar_busy    <= 1'b0;
                            burst_done <= accept && last_beat && !burst_abort;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addr_burst_reg.sv
// Directed and randomized burst checks against a closed-form address model.
module tb_addr_burst_reg;

    localparam int AW   = 8;
    localparam int LW   = 4;
    localparam int STEP = 1;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic          LDAR = 1'b0;
    logic          burst_start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          dir = 1'b0;
    logic          burst_abort = 1'b0;
    logic          addr_ready = 1'b0;
    logic [AW-1:0] ABUSD;
    logic          addr_valid;
    logic          ar_busy;
    logic          burst_done;
    logic          addr_err;

    int vectors = 0;
    int miscompares = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] exp_final;
    logic          exp_done;
    logic          exp_err;

`ifdef ADDR_BOUND_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    addr_burst_reg #(
        .AW   (AW),
        .LW   (LW),
        .STEP (STEP)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .load_addr   (load_addr),
        .LDAR        (LDAR),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .dir         (dir),
        .burst_abort (burst_abort),
        .addr_ready  (addr_ready),
        .ABUSD       (ABUSD),
        .addr_valid  (addr_valid),
        .ar_busy     (ar_busy),
        .burst_done  (burst_done),
        .addr_err    (addr_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat i sits at base +/- i*STEP; the burst ends on the last beat,
    // on the abort beat, or (bounded builds) on a beat whose successor leaves 0..2^AW-1.
    task automatic model(input int base, input int len, input bit d,
                         input int abort_at);
        int sgn;
        int nxt;
        sgn = d ? -1 : 1;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_final = AW'(base);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(AW'(base + sgn * i * STEP));
            nxt = base + sgn * (i + 1) * STEP;
            if (BOUND && i < len - 1 && (nxt < 0 || nxt > (1 << AW) - 1)) begin
                exp_final = AW'(base + sgn * i * STEP);
                exp_err = 1'b1;
                break;
            end
            exp_final = AW'(nxt);
            if (i == abort_at) break;
            if (i == len - 1) exp_done = 1'b1;
        end
    endtask

    task automatic burst(input string tag, input logic [AW-1:0] base,
                         input int len, input bit d, input bit with_ld,
                         input logic [31:0] rpat, input bit rnd,
                         input int abort_at);
        int  k;
        int  c;
        bit  fin;
        bit  r;
        model(int'(base), len, d, abort_at);
        if (!with_ld) begin
            load_addr = base;
            LDAR = 1'b1;
            @(negedge sys_clk);
            LDAR = 1'b0;
            chk({tag, ".ld"}, 32'(ABUSD), 32'(base));
            chk({tag, ".ld_valid"}, 32'(addr_valid), 0);
        end
        load_addr = base;
        LDAR = with_ld;
        burst_start = 1'b1;
        burst_len = LW'(len);
        dir = d;
        @(negedge sys_clk);
        LDAR = 1'b0;
        burst_start = 1'b0;
        k = 0;
        c = 0;
        fin = 1'b0;
        while (!fin && c < 100) begin
            chk({tag, ".valid"}, 32'(addr_valid), 1);
            chk({tag, ".busy"}, 32'(ar_busy), 1);
            chk({tag, ".beat"}, 32'(ABUSD), 32'(exp_q[k]));
            r = rnd ? 1'($urandom_range(0, 1)) : (c < 32 ? rpat[c] : 1'b1);
            addr_ready = r;
            burst_abort = r && (k == abort_at);
            // Idle-only commands while stalled must be ignored.
            LDAR = !r;
            burst_start = !r;
            load_addr = ~exp_q[k];
            if (r) begin
                k++;
                if (k == exp_q.size()) fin = 1'b1;
            end
            c++;
            @(negedge sys_clk);
            addr_ready = 1'b0;
            burst_abort = 1'b0;
            LDAR = 1'b0;
            burst_start = 1'b0;
        end
        if (!fin) chk({tag, ".timeout"}, 1, 0);
        chk({tag, ".end_valid"}, 32'(addr_valid), 0);
        chk({tag, ".end_busy"}, 32'(ar_busy), 0);
        chk({tag, ".done"}, 32'(burst_done), 32'(exp_done));
        chk({tag, ".err"}, 32'(addr_err), 32'(exp_err));
        chk({tag, ".final"}, 32'(ABUSD), 32'(exp_final));
        @(negedge sys_clk);
        chk({tag, ".done_pulse"}, 32'(burst_done), 0);
        chk({tag, ".err_pulse"}, 32'(addr_err), 0);
        chk({tag, ".hold"}, 32'(ABUSD), 32'(exp_final));
    endtask

    initial begin
        #12;
        chk("rst.abusd", 32'(ABUSD), 0);
        chk("rst.valid", 32'(addr_valid), 0);
        chk("rst.busy", 32'(ar_busy), 0);
        chk("rst.done", 32'(burst_done), 0);
        chk("rst.err", 32'(addr_err), 0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);

        load_addr = 8'h20;
        LDAR = 1'b1;
        @(negedge sys_clk);
        LDAR = 1'b0;
        chk("t1.abusd", 32'(ABUSD), 32'h20);
        chk("t1.valid", 32'(addr_valid), 0);
        chk("t1.busy", 32'(ar_busy), 0);

        burst("t2", 8'h20, 4, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, -1);
        burst("t3", 8'h20, 4, 1'b0, 1'b0, 32'hFFFF_FFF9, 1'b0, -1);
        burst("t4", 8'h05, 3, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, -1);
        burst("t5", 8'h10, 5, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1);
        burst("t6", 8'hFE, 4, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, -1);
        burst("t6d", 8'h01, 3, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, -1);
        burst("lastwrap", 8'hFF, 1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, -1);

        // Zero-length start is a no-op.
        burst_start = 1'b1;
        burst_len = '0;
        @(negedge sys_clk);
        burst_start = 1'b0;
        chk("len0.valid", 32'(addr_valid), 0);
        chk("len0.busy", 32'(ar_busy), 0);
        @(negedge sys_clk);
        chk("len0.done", 32'(burst_done), 0);

        for (int i = 0; i < 40; i++) begin
            burst("rnd", 8'($urandom), int'($urandom_range(1, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  32'hFFFF_FFFF, 1'b1, -1);
        end

        // Reset mid-burst clears everything at once.
        load_addr = 8'h40;
        LDAR = 1'b1;
        burst_start = 1'b1;
        burst_len = 4'd6;
        dir = 1'b0;
        @(negedge sys_clk);
        LDAR = 1'b0;
        burst_start = 1'b0;
        addr_ready = 1'b1;
        @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        #1;
        chk("midrst.abusd", 32'(ABUSD), 0);
        chk("midrst.valid", 32'(addr_valid), 0);
        chk("midrst.busy", 32'(ar_busy), 0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("midrst.done", 32'(burst_done), 0);
        chk("midrst.idle", 32'(addr_valid), 0);
        addr_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
